vram_write_scheduler: RTL and testbench

- Posts CPU VRAM writes into a FIFO and replays them into the GPU VRAM write port only while the video timing reports writable.
- Closes the gap where VRAM writes reach the text/foreground/background memories mid-scanline.
- Sits between the CPU bus decode and the gpu write-side inputs (vram_address, data_in, write_enable, SELECT_* strobes).
- Caps writes per blanking window so a long backlog cannot overrun it.

---
 rtl/mapache64_pkg.sv | 21 ++
 rtl/vram_write_scheduler_fifo.sv | 50 +++++
 rtl/vram_write_scheduler.sv | 123 ++++++++++++
 tb/tb_vram_write_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mapache64_pkg.sv
// Shared mapache64 GPU types: VRAM address/select widths, the posted write
// request record and the write scheduler state encoding.
package mapache64;

  localparam int VramAddrWidth = 16;
  localparam int VramSelWidth  = 6;

  // sel is one-hot {txbl, obm, ntbl, pmb, pmf, vram}, MSB first.
  typedef struct packed {
    logic [VramAddrWidth-1:0] addr;
    logic [7:0]               data;
    logic [VramSelWidth-1:0]  sel;
  } vram_wreq_t;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    DRAIN = 2'd1,
    SPENT = 2'd2
  } wsched_state_e;

endpackage

// File: rtl/vram_write_scheduler_fifo.sv
// Synchronous FIFO for posted VRAM writes. Extra pointer MSB distinguishes
// full from empty, so all DEPTH entries are usable.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        gpu_clk,
  input  logic        rst,
  input  logic        push,
  input  T            push_data,
  input  logic        pop,
  input  logic        flush,
  output T            head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // flush wins over a same-cycle push or pop
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge gpu_clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge gpu_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/vram_write_scheduler.sv
// Posts CPU VRAM writes and replays them only while video timing is writable,
// with an optional per-window write budget. Optional stats: VRAM_WSCHED_STATS_EN.
module vram_write_scheduler
  import mapache64::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = VramAddrWidth,
  parameter int MAX_PER_WINDOW = 0
) (
  input  logic                     gpu_clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [7:0]               req_data,
  input  logic [5:0]               req_sel,
  input  logic                     flush,
  input  logic                     writable,
  output logic [ADDR_W-1:0]        vram_address,
  output logic [7:0]               data_in_o,
  output logic [5:0]               sel_o,
  output logic                     write_enable,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [1:0]               state_o
`ifdef VRAM_WSCHED_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [15:0]              carry_count
`endif
);

  vram_wreq_t                push_req;
  vram_wreq_t                head;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;
  wsched_state_e             state_q;
  wsched_state_e             state_d;
  logic                      budget_hit;

  assign push_req = '{addr: VramAddrWidth'(req_addr), data: req_data, sel: req_sel};

  sync_fifo #(
    .T     (vram_wreq_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .gpu_clk   (gpu_clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (write_enable),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Strobe derives only from registered state/head and the live window, so a
  // falling writable kills the write in the same cycle.
  assign write_enable = (state_q == DRAIN) && writable && !empty && !flush;
  assign req_ready    = !full;
  assign pending      = count;
  assign vram_address = empty ? '0 : ADDR_W'(head.addr);
  assign data_in_o    = empty ? '0 : head.data;
  assign sel_o        = write_enable ? head.sel : '0;
  assign state_o      = state_q;

  if (MAX_PER_WINDOW == 0) begin : g_unlimited
    assign budget_hit = 1'b0;
  end else begin : g_budget
    localparam int             BW   = $clog2(MAX_PER_WINDOW + 1);
    localparam logic [BW-1:0]  BMAX = BW'(MAX_PER_WINDOW);
    logic [BW-1:0] budget_q;

    always_ff @(posedge gpu_clk) begin
      if (rst || state_q == WAIT) begin
        budget_q <= '0;
      end else if (write_enable && budget_q != BMAX) begin
        budget_q <= budget_q + 1'b1;
      end
    end

    assign budget_hit = write_enable && (budget_q == BMAX - 1'b1);
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  // NOTE: next state defaults to the current one so no path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (writable) state_d = DRAIN;
      DRAIN: begin
        if (!writable)       state_d = WAIT;
        else if (budget_hit) state_d = SPENT;
      end
      SPENT:   if (!writable) state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

`ifdef VRAM_WSCHED_STATS_EN
  logic window_close;
  assign window_close = (state_q != WAIT) && !writable;

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      drop_count  <= '0;
      carry_count <= '0;
    end else begin
      if (req_valid && !req_ready && drop_count != 16'hFFFF)
        drop_count <= drop_count + 1'b1;
      if (window_close && count != '0 && carry_count != 16'hFFFF)
        carry_count <= carry_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: an unlimited instance and a
// MAX_PER_WINDOW=2 instance share stimulus; expected writes go through queues.
module tb_vram_write_scheduler;
  import mapache64::*;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic [5:0]  req_sel = '0;
  logic        flush = 1'b0;
  logic        writable = 1'b0;

  logic        a_ready, c_ready;
  logic [15:0] a_addr, c_addr;
  logic [7:0]  a_data, c_data;
  logic [5:0]  a_sel, c_sel;
  logic        a_we, c_we;
  logic [4:0]  a_pend, c_pend;
  logic [1:0]  a_state, c_state;
`ifdef VRAM_WSCHED_STATS_EN
  logic [15:0] a_drop, c_drop, a_carry, c_carry;
`endif

  int checks = 0;
  int errors = 0;
  int wr_a = 0;
  int wr_c = 0;
  int base_a, base_c;
  vram_wreq_t q[$];
  vram_wreq_t qc[$];

  always #5 gpu_clk = ~gpu_clk;

  vram_write_scheduler #(.DEPTH(16), .ADDR_W(16), .MAX_PER_WINDOW(0)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel), .flush(flush),
    .writable(writable), .vram_address(a_addr), .data_in_o(a_data), .sel_o(a_sel),
    .write_enable(a_we), .pending(a_pend), .state_o(a_state)
`ifdef VRAM_WSCHED_STATS_EN
    , .drop_count(a_drop), .carry_count(a_carry)
`endif
  );

  vram_write_scheduler #(.DEPTH(16), .ADDR_W(16), .MAX_PER_WINDOW(2)) dut_cap (
    .gpu_clk(gpu_clk), .rst(rst), .req_valid(req_valid), .req_ready(c_ready),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel), .flush(flush),
    .writable(writable), .vram_address(c_addr), .data_in_o(c_data), .sel_o(c_sel),
    .write_enable(c_we), .pending(c_pend), .state_o(c_state)
`ifdef VRAM_WSCHED_STATS_EN
    , .drop_count(c_drop), .carry_count(c_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    writable = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    step();
    step();
    q.delete();
    qc.delete();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d, input logic [5:0] s,
                      input bit accepted);
    vram_wreq_t e;
    e = '{addr: a, data: d, sel: s};
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_sel = s;
    if (accepted) begin
      q.push_back(e);
      qc.push_back(e);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Every issued write is popped from the scoreboard and compared in order.
  always @(negedge gpu_clk) begin
    vram_wreq_t e;
    if (!rst && a_we) begin
      wr_a++;
      if (q.size() == 0) check("a_unexpected_write", 1, 0);
      else begin
        e = q.pop_front();
        check("a_wr_addr", 32'(a_addr), 32'(e.addr));
        check("a_wr_data", 32'(a_data), 32'(e.data));
        check("a_wr_sel", 32'(a_sel), 32'(e.sel));
      end
    end
    if (!rst && c_we) begin
      wr_c++;
      if (qc.size() == 0) check("c_unexpected_write", 1, 0);
      else begin
        e = qc.pop_front();
        check("c_wr_addr", 32'(c_addr), 32'(e.addr));
        check("c_wr_data", 32'(c_data), 32'(e.data));
        check("c_wr_sel", 32'(c_sel), 32'(e.sel));
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", 32'(a_ready), 1);
    check("rst_pending", 32'(a_pend), 0);
    check("rst_we", 32'(a_we), 0);
    check("rst_sel", 32'(a_sel), 0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_data", 32'(a_data), 0);
    check("rst_state", 32'(a_state), 32'(WAIT));

    // Three writes held while not writable, then drained in order
    for (int i = 0; i < 3; i++) push(16'h010 + 16'(i), 8'hA1 + 8'(i), 6'b100000, 1'b1);
    check("t1_no_write", 32'(wr_a), 0);
    check("t1_pending3", 32'(a_pend), 3);
    check("t1_ready", 32'(a_ready), 1);
    writable = 1'b1;
    run(6);
    check("t1_writes", 32'(wr_a), 3);
    check("t1_pending0", 32'(a_pend), 0);
    check("t1_q_empty", 32'(q.size()), 0);

    // Budget of 2 per window on the capped instance
    do_reset();
    base_a = wr_a;
    base_c = wr_c;
    for (int i = 0; i < 5; i++) push(16'h100 + 16'(i), 8'h30 + 8'(i), 6'b000001, 1'b1);
    writable = 1'b1;
    run(10);
    check("t2_c_writes_w1", 32'(wr_c - base_c), 2);
    check("t2_c_state_spent", 32'(c_state), 32'(SPENT));
    check("t2_c_pending3", 32'(c_pend), 3);
    check("t2_a_writes_all", 32'(wr_a - base_a), 5);
    writable = 1'b0;
    run(2);
    check("t2_c_state_wait", 32'(c_state), 32'(WAIT));
    writable = 1'b1;
    run(10);
    check("t2_c_writes_w2", 32'(wr_c - base_c), 4);
    check("t2_c_pending1", 32'(c_pend), 1);
    writable = 1'b0;
    run(2);
    writable = 1'b1;
    run(10);
    check("t2_c_writes_w3", 32'(wr_c - base_c), 5);
    check("t2_c_pending0", 32'(c_pend), 0);
    check("t2_c_state_drain", 32'(c_state), 32'(DRAIN));

    // Fill to DEPTH; the 17th request is refused
    do_reset();
    for (int i = 0; i < 16; i++) push(16'h200 + 16'(i), 8'(i * 7), 6'b000100, 1'b1);
    check("t3_ready_full", 32'(a_ready), 0);
    check("t3_pending16", 32'(a_pend), 16);
    push(16'h2FF, 8'hEE, 6'b000100, 1'b0);
    check("t3_pending_held", 32'(a_pend), 16);
`ifdef VRAM_WSCHED_STATS_EN
    check("t3_drop_count", 32'(a_drop), 1);
`endif
    writable = 1'b1;
    run(20);
    check("t3_pending0", 32'(a_pend), 0);
    check("t3_q_empty", 32'(q.size()), 0);
    check("t3_ready_again", 32'(a_ready), 1);

    // Window closes with 4 entries left
    do_reset();
    base_a = wr_a;
    for (int i = 0; i < 6; i++) push(16'h300 + 16'(i), 8'h50 + 8'(i), 6'b010000, 1'b1);
    writable = 1'b1;
    run(3);
    writable = 1'b0;
    #1;
    check("t4_we_drops", 32'(a_we), 0);
    check("t4_pending4", 32'(a_pend), 4);
    step();
    check("t4_state_wait", 32'(a_state), 32'(WAIT));
    check("t4_pending_held", 32'(a_pend), 4);
    check("t4_writes2", 32'(wr_a - base_a), 2);
`ifdef VRAM_WSCHED_STATS_EN
    check("t4_carry_count", 32'(a_carry), 1);
`endif
    writable = 1'b1;
    run(10);
    check("t4_pending0", 32'(a_pend), 0);
    check("t4_q_empty", 32'(q.size()), 0);

    // flush with a same-cycle push while draining
    do_reset();
    for (int i = 0; i < 5; i++) push(16'h400 + 16'(i), 8'h60 + 8'(i), 6'b000010, 1'b1);
    writable = 1'b1;
    step();
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 16'h0AA;
    q.delete();
    qc.delete();
    #1;
    check("t5_we_blocked", 32'(a_we), 0);
    check("t5_pending5", 32'(a_pend), 5);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    check("t5_pending0", 32'(a_pend), 0);
    check("t5_state_kept", 32'(a_state), 32'(DRAIN));
    base_a = wr_a;
    run(4);
    check("t5_no_writes", 32'(wr_a - base_a), 0);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h500 + 16'(i), 8'h70 + 8'(i), 6'b001000, 1'b1);
    writable = 1'b1;
    run(3);
    check("t6_pending6", 32'(a_pend), 6);
    rst = 1'b1;
    step();
    check("t6_pending0", 32'(a_pend), 0);
    check("t6_ready", 32'(a_ready), 1);
    check("t6_state", 32'(a_state), 32'(WAIT));
    check("t6_we", 32'(a_we), 0);
    check("t6_sel", 32'(a_sel), 0);
    check("t6_addr", 32'(a_addr), 0);
    check("t6_data", 32'(a_data), 0);
    writable = 1'b0;
    q.delete();
    qc.delete();
    rst = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
